// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word access at a time on a simple req/ack memory port.
// Latency: start->done >= 2 cycles (1 for faults); mem_req waits on mem_ack up to TIMEOUT cycles; start is ignored while busy.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  fault_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    state_t        state_q;
    logic [CW-1:0] wait_q;
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [1:0]    addr_lo_q;
    logic          done_q;
    logic [1:0]    fault_q;
    logic [31:0]   rdata_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [29:0]   mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_wdata_q;

    logic          illegal;
    logic          misaligned;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;
    logic [31:0]   load_d;

    // Decode of the incoming request, only meaningful in IDLE.
    always_comb begin
        illegal    = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (is_store_i && funct3_i[2]);
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        case (funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << addr_i[1:0];
                wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata_i;
            end
        endcase
    end

    // Lane extraction of the returned word for the latched request.
    always_comb begin
        case (addr_lo_q)
            2'd0:    lbyte = mem_rdata_i[7:0];
            2'd1:    lbyte = mem_rdata_i[15:8];
            2'd2:    lbyte = mem_rdata_i[23:16];
            default: lbyte = mem_rdata_i[31:24];
        endcase
        lhalf = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_d = {{24{lbyte[7]}}, lbyte};
            3'b001:  load_d = {{16{lhalf[15]}}, lhalf};
            3'b100:  load_d = {24'b0, lbyte};
            3'b101:  load_d = {16'b0, lhalf};
            default: load_d = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            done_q      <= 1'b0;
            fault_q     <= 2'b00;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        is_store_q <= is_store_i;
                        funct3_q   <= funct3_i;
                        addr_lo_q  <= addr_i[1:0];
                        if (illegal || misaligned) begin
                            state_q <= FAULT;
                            done_q  <= 1'b1;
                            fault_q <= illegal ? 2'b10 : 2'b01;
                        end else begin
                            state_q     <= REQ;
                            wait_q      <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_i;
                            mem_addr_q  <= addr_i[31:2];
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    // An ack in the last allowed cycle still completes the access.
                    if (mem_ack_i) begin
                        state_q   <= RESP;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'b0000;
                        if (!is_store_q) rdata_q <= load_d;
                    end else if (wait_q == CW'(TIMEOUT - 1)) begin
                        state_q   <= FAULT;
                        done_q    <= 1'b1;
                        fault_q   <= 2'b11;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'b0000;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign fault_o     = fault_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with TIMEOUT=4.
module tb_load_store_unit;
    logic        clk;
    logic        rst;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  fault_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int vec;
    int errs;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .is_store_i(is_store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; on return the bench sits in cycle 1.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        is_store_i = st;
        funct3_i   = f3;
        addr_i     = a;
        wdata_i    = wd;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 0; is_store_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        #12;
        vec++;
        if ({busy_o, done_o, fault_o, mem_req_o, mem_we_o, mem_be_o} !== 9'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b required 0", {busy_o, done_o, fault_o, mem_req_o, mem_we_o, mem_be_o});
        end
        vec++;
        if ({rdata_o, mem_addr_o, mem_wdata_o} !== 94'b0) begin
            errs++; $display("FAIL reset_data: got %h required 0", {rdata_o, mem_addr_o, mem_wdata_o});
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_lb();
        issue(1'b0, 3'b000, 32'h6, 32'h0);
        vec++;
        if ({mem_req_o, mem_we_o, mem_be_o, busy_o, done_o} !== 8'b1_0_0100_1_0) begin
            errs++; $display("FAIL lb_req: got %b required 10010010", {mem_req_o, mem_we_o, mem_be_o, busy_o, done_o});
        end
        vec++;
        if (mem_addr_o !== 30'h1) begin
            errs++; $display("FAIL lb_addr: got %h required 1", mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12F45678;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        vec++;
        if ({done_o, fault_o, mem_req_o, mem_be_o} !== 8'b1_00_0_0000) begin
            errs++; $display("FAIL lb_done: got %b required 10000000", {done_o, fault_o, mem_req_o, mem_be_o});
        end
        vec++;
        if (rdata_o !== 32'hFFFFFFF4) begin
            errs++; $display("FAIL lb_rdata: got %h required fffffff4", rdata_o);
        end
        tick();
        vec++;
        if ({busy_o, done_o} !== 2'b00) begin
            errs++; $display("FAIL lb_idle: got %b required 00", {busy_o, done_o});
        end
    endtask

    task automatic test_sh();
        issue(1'b1, 3'b001, 32'h2, 32'hAAAA5A5A);
        for (int c = 1; c <= 4; c++) begin
            vec++;
            if ({mem_req_o, mem_we_o, mem_be_o, done_o} !== 7'b1_1_1100_0 || mem_wdata_o !== 32'h5A5A5A5A || mem_addr_o !== 30'h0) begin
                errs++; $display("FAIL sh_hold c%0d: got req/we/be/done=%b wdata=%h addr=%h required 1111000 5a5a5a5a 0",
                                 c, {mem_req_o, mem_we_o, mem_be_o, done_o}, mem_wdata_o, mem_addr_o);
            end
            if (c == 4) mem_ack_i = 1'b1;
            tick();
        end
        mem_ack_i = 1'b0;
        vec++;
        if ({done_o, fault_o, mem_req_o, mem_we_o} !== 5'b1_00_0_0) begin
            errs++; $display("FAIL sh_done: got %b required 10000", {done_o, fault_o, mem_req_o, mem_we_o});
        end
        vec++;
        if (rdata_o !== 32'hFFFFFFF4) begin
            errs++; $display("FAIL sh_rdata_kept: got %h required fffffff4", rdata_o);
        end
        tick();
    endtask

    task automatic test_faults();
        logic [3:0]  f3s [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
        logic        sts [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ads [4] = '{32'h3, 32'h0, 32'h3, 32'h1};
        logic [1:0]  exp [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            issue(sts[i], f3s[i][2:0], ads[i], 32'h0);
            vec++;
            if ({done_o, fault_o, mem_req_o, busy_o} !== {1'b1, exp[i], 1'b0, 1'b1}) begin
                errs++; $display("FAIL fault_%0d: got done/fault/req/busy=%b required %b", i,
                                 {done_o, fault_o, mem_req_o, busy_o}, {1'b1, exp[i], 1'b0, 1'b1});
            end
            tick();
            vec++;
            if ({busy_o, done_o, mem_req_o, rdata_o} !== {3'b000, 32'hFFFFFFF4}) begin
                errs++; $display("FAIL fault_after_%0d: got %h required fffffff4 idle", i, {busy_o, done_o, mem_req_o, rdata_o});
            end
        end
    endtask

    task automatic test_timeout();
        issue(1'b0, 3'b101, 32'h2, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            vec++;
            if ({mem_req_o, mem_be_o, done_o} !== 6'b1_1100_0) begin
                errs++; $display("FAIL to_wait c%0d: got %b required 111000", c, {mem_req_o, mem_be_o, done_o});
            end
            tick();
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        vec++;
        if ({mem_req_o, done_o, fault_o} !== 4'b0_1_11) begin
            errs++; $display("FAIL to_fault: got %b required 0111", {mem_req_o, done_o, fault_o});
        end
        tick();
        tick();
        mem_ack_i = 1'b0;
        vec++;
        if ({busy_o, done_o, mem_req_o, rdata_o} !== {3'b000, 32'hFFFFFFF4}) begin
            errs++; $display("FAIL to_late_ack: got %h required idle fffffff4", {busy_o, done_o, mem_req_o, rdata_o});
        end
        // Ack in the final allowed cycle beats the timeout.
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; end
            tick();
        end
        mem_ack_i = 1'b0;
        vec++;
        if ({done_o, fault_o} !== 3'b1_00 || rdata_o !== 32'hCAFEF00D) begin
            errs++; $display("FAIL to_ack_wins: got done/fault=%b rdata=%h required 100 cafef00d", {done_o, fault_o}, rdata_o);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        vec++;
        if (mem_req_o !== 1'b1) begin
            errs++; $display("FAIL rst_pre_req: got %b required 1", mem_req_o);
        end
        rst = 1'b1;
        #1;
        vec++;
        if ({mem_req_o, busy_o, done_o, rdata_o} !== 35'b0) begin
            errs++; $display("FAIL rst_async: got %h required 0", {mem_req_o, busy_o, done_o, rdata_o});
        end
        #2 rst = 1'b0;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        vec++;
        if ({busy_o, done_o, mem_req_o} !== 3'b000) begin
            errs++; $display("FAIL rst_no_done: got %b required 000", {busy_o, done_o, mem_req_o});
        end
        issue(1'b0, 3'b100, 32'h1, 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000F000;
        tick();
        mem_ack_i = 1'b0;
        vec++;
        if (done_o !== 1'b1 || rdata_o !== 32'h000000F0) begin
            errs++; $display("FAIL rst_lbu: got done=%b rdata=%h required 1 000000f0", done_o, rdata_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_req  = 7'b1001001;
        logic [6:0] exp_done = 7'b0100100;
        logic [6:0] exp_busy = 7'b1101101;
        is_store_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00000080;
        start_i = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            vec++;
            if ({mem_req_o, done_o, busy_o} !== {exp_req[6-c], exp_done[6-c], exp_busy[6-c]}) begin
                errs++; $display("FAIL b2b c%0d: got req/done/busy=%b required %b", c + 1,
                                 {mem_req_o, done_o, busy_o}, {exp_req[6-c], exp_done[6-c], exp_busy[6-c]});
            end
            if (c == 6) start_i = 1'b0;
            tick();
        end
        mem_ack_i = 1'b0;
        vec++;
        if ({done_o, rdata_o} !== {1'b1, 32'hFFFFFF80}) begin
            errs++; $display("FAIL b2b_last: got done=%b rdata=%h required 1 ffffff80", done_o, rdata_o);
        end
        tick();
        vec++;
        if ({busy_o, mem_req_o} !== 2'b00) begin
            errs++; $display("FAIL b2b_idle: got %b required 00", {busy_o, mem_req_o});
        end
    endtask

    initial begin
        vec = 0;
        errs = 0;
        test_reset();
        test_lb();
        test_sh();
        test_faults();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles spent waiting for mem_ack before a timeout fault is reported.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  core request strobe, sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  access type: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use SB 000, SH 001, SW 010.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 fault  output  2  valid while done is high: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-012 rdata  output  32  extended load result.
REQ-013 mem_req  output  1  memory request, held until acknowledged.
REQ-014 mem_we  output  1  write enable, qualified by mem_req.
REQ-015 mem_addr  output  30  word address = addr[31:2].
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  32  lane-aligned store data.
REQ-018 mem_ack  input  1  memory completion; may be asserted in the same cycle mem_req first rises.
REQ-019 mem_rdata  input  32  read word, valid in the cycle mem_ack is high.

Function
REQ-020 FSM states SHALL be IDLE, REQ, RESP and FAULT.
REQ-021 In IDLE, start SHALL latch is_store, funct3, addr and wdata.
- The next state SHALL be FAULT if the request is illegal or misaligned, otherwise REQ.
REQ-022 Illegal requests: funct3 011, 110 or 111, or a store with funct3[2]=1; illegal SHALL take priority over misaligned.
REQ-023 Misaligned requests: a halfword access with addr[0]=1, or a word access with addr[1:0]!=00.
REQ-024 FAULT SHALL last 1 cycle with done=1 and the fault code, never assert mem_req, then return to IDLE.
REQ-025 In REQ, mem_req SHALL be 1 and mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable until mem_ack.
REQ-026 Byte enables SHALL be:
- byte: 0001<<addr[1:0]
- half: 0011<<addr[1:0]
- word: 1111
REQ-027 mem_wdata SHALL be:
- byte: wdata[7:0] replicated x4
- half: wdata[15:0] replicated x2
- word: wdata
REQ-028 Load extraction SHALL be:
- byte: mem_rdata[8*addr[1:0]+:8]
- half: mem_rdata[16*addr[1]+:16]
- LB/LH sign-extend, LBU/LHU zero-extend
- LW is passed unchanged
REQ-029 On mem_ack in REQ, a load SHALL register the extracted value into rdata and the FSM SHALL move to RESP.
REQ-030 RESP SHALL last 1 cycle with done=1 and fault=00, then return to IDLE.
REQ-031 rdata SHALL hold its value until the next successful load; stores and faults SHALL NOT modify rdata.
REQ-032 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack.
- When it reaches TIMEOUT, the FSM SHALL go to FAULT with code 11 and drop mem_req.
- A mem_ack arriving in that same cycle SHALL win over the timeout.
REQ-033 Latency:
- start in cycle 0 gives mem_req in cycle 1.
- mem_ack in cycle N gives done in cycle N+1.
- Minimum latency from start to done is 2 cycles.
- An alignment or illegal fault gives done in cycle 1.
REQ-034 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-035 A start in the same cycle as done SHALL be ignored, because the FSM is not yet in IDLE.
REQ-036 mem_ack outside REQ SHALL be ignored.
REQ-037 When mem_req=0, mem_we and mem_be SHALL be 0.

Reset
REQ-038 rst SHALL immediately force IDLE and clear the wait counter.
- Outputs SHALL be zero: busy, done, fault, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
REQ-039 rst asserted in REQ SHALL drop mem_req in the same cycle without producing done.
- After rst is released, the first start SHALL behave as from power-up.

Verification
REQ-040 LB, addr=0x00000006, mem_rdata=0x12F45678, ack in cycle 1:
- mem_be=0100, mem_addr=0x1
- done in cycle 2, rdata=0xFFFFFFF4, fault=00
REQ-041 SH, addr=0x00000002, wdata=0xAAAA5A5A, ack delayed 3 cycles:
- mem_we=1, mem_be=1100, mem_wdata=0x5A5A5A5A held for 4 cycles
- rdata unchanged
REQ-042 LW at addr=0x00000003:
- done in cycle 1 with fault=01
- mem_req never asserted
- a store with funct3=100 gives fault=10
REQ-043 LHU at addr=0x2 with no ack and TIMEOUT=4:
- mem_req drops after 4 cycles
- done with fault=11
- a late mem_ack is ignored
REQ-044 rst pulsed while mem_req=1:
- mem_req=0 asynchronously and no done
- the next LBU at addr=0x1 with mem_rdata=0x0000F000 gives rdata=0x000000F0
REQ-045 start held high continuously:
- one request per transaction
- each new request is accepted only in an IDLE cycle after done
